sc_mul_sequencer: RTL and testbench

Job sequencer for the team's bipolar stochastic multiplier. It accepts one job at a time over a valid/ready port: two 4-bit probabilities and a stream-length code. It reseeds the two LFSRs, runs the stochastic-number (SN) multiply for exactly N bit-cycles, counts the ones in the product stream, and returns the ones count and the signed bipolar value over a second valid/ready port. It sits between the tile's host-facing register or pin logic and the SN datapath, and is the only block that steps or reseeds that datapath.

---
 rtl/sc_pkg.sv | 29 ++
 rtl/sc_bipolar_mul_core.sv | 52 +++++
 rtl/sc_mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_sc_mul_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic multiplier sequencer.
package sc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSeed,
      StRun,
      StDrain,
      StDone
   } state_t;

   localparam logic [30:0] SEED_A_DEF = 31'd1;
   localparam logic [30:0] SEED_B_DEF = 31'd2;

   // Feedback taps of the two 31-bit LFSRs
   localparam int unsigned TAP_A_LO = 27;
   localparam int unsigned TAP_A_HI = 30;
   localparam int unsigned TAP_B_LO = 12;
   localparam int unsigned TAP_B_HI = 16;

   // Wide enough for a ones count of up to 128
   localparam int unsigned CNT_W = 8;

   // Stream length code to bit count: 16, 32, 64 or 128
   function automatic logic [CNT_W-1:0] len_to_n(input logic [1:0] len);
      return CNT_W'(16) << len;
   endfunction

endpackage

// File: rtl/sc_bipolar_mul_core.sv
// SN datapath: two LFSRs, threshold comparators and the XNOR product register.
module sc_bipolar_mul_core
   import sc_pkg::*;
#(
   parameter logic [30:0] SEED_A = SEED_A_DEF,
   parameter logic [30:0] SEED_B = SEED_B_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] prob_a,
   input  logic [3:0] prob_b,
   output logic       prod
);

   logic [30:0] lfsr_a_q;
   logic [30:0] lfsr_b_q;
   logic        bit_a_q;
   logic        bit_b_q;
   logic        prod_q;

   // LFSRs reseed on load and step only when enabled; they hold otherwise.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         lfsr_a_q <= SEED_A;
         lfsr_b_q <= SEED_B;
      end else if (load) begin
         lfsr_a_q <= SEED_A;
         lfsr_b_q <= SEED_B;
      end else if (en) begin
         lfsr_a_q <= {lfsr_a_q[29:0], lfsr_a_q[TAP_A_LO] ^ lfsr_a_q[TAP_A_HI]};
         lfsr_b_q <= {lfsr_b_q[29:0], lfsr_b_q[TAP_B_LO] ^ lfsr_b_q[TAP_B_HI]};
      end
   end

   // Free-running two-stage pipeline; the sequencer's valid pipe masks stale bits.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         bit_a_q <= 1'b0;
         bit_b_q <= 1'b0;
         prod_q  <= 1'b0;
      end else begin
         bit_a_q <= (lfsr_a_q[30:27] < prob_a);
         bit_b_q <= (lfsr_b_q[30:27] < prob_b);
         prod_q  <= ~(bit_a_q ^ bit_b_q);
      end
   end

   assign prod = prod_q;

endmodule

// File: rtl/sc_mul_sequencer.sv
// Job sequencer: accepts one job, runs N SN bit-cycles, returns ones count and bipolar value.
module sc_mul_sequencer
   import sc_pkg::*;
#(
   parameter logic [30:0] SEED_A = SEED_A_DEF,
   parameter logic [30:0] SEED_B = SEED_B_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_prob_a,
   input  logic [3:0]        in_prob_b,
   input  logic [1:0]        in_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_ones,
   output logic signed [8:0] out_bipolar,
   output logic              busy
);

   state_t                  state_q, state_d;
   logic [3:0]              prob_a_q, prob_b_q;
   logic [1:0]              len_q;
   logic [CNT_W-1:0]        issue_q;
   logic [CNT_W-1:0]        ones_q;
   logic [CNT_W-1:0]        ones_next;
   logic [1:0]              vpipe_q;
   logic [CNT_W-1:0]        n;
   logic                    core_load;
   logic                    core_en;
   logic                    prod;
   logic signed [9:0]       bip_next;
   logic [7:0]              out_ones_q;
   logic signed [8:0]       out_bipolar_q;

   assign n         = len_to_n(len_q);
   // vpipe_q[1] lines up with the core's prod register
   assign ones_next = ones_q + {{(CNT_W-1){1'b0}}, prod & vpipe_q[1]};
   assign bip_next  = $signed({1'b0, ones_next, 1'b0}) - $signed({2'b00, n});

   sc_bipolar_mul_core #(
      .SEED_A (SEED_A),
      .SEED_B (SEED_B)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .en     (core_en),
      .prob_a (prob_a_q),
      .prob_b (prob_b_q),
      .prod   (prod)
   );

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state and handshake/control outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      core_load = 1'b0;
      core_en   = 1'b0;
      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = StSeed;
         end
         StSeed: begin
            core_load = 1'b1;
            state_d   = StRun;
         end
         StRun: begin
            core_en = 1'b1;
            if (issue_q == n - CNT_W'(1)) state_d = StDrain;
         end
         StDrain: begin
            // Pipe enters DRAIN as 2'b11; 2'b10 marks the second drain cycle
            if (!vpipe_q[0]) state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Job parameters captured on accept.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         prob_a_q <= 4'd0;
         prob_b_q <= 4'd0;
         len_q    <= 2'd0;
      end else if (state_q == StIdle && in_valid) begin
         prob_a_q <= in_prob_a;
         prob_b_q <= in_prob_b;
         len_q    <= in_len;
      end
   end

   // Issue counter, valid pipe and ones counter.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         issue_q <= '0;
         ones_q  <= '0;
         vpipe_q <= 2'b00;
      end else begin
         case (state_q)
            StSeed: begin
               issue_q <= '0;
               ones_q  <= '0;
               vpipe_q <= 2'b00;
            end
            StRun: begin
               issue_q <= issue_q + CNT_W'(1);
               vpipe_q <= {vpipe_q[0], 1'b1};
               ones_q  <= ones_next;
            end
            StDrain: begin
               vpipe_q <= {vpipe_q[0], 1'b0};
               ones_q  <= ones_next;
            end
            default: ;
         endcase
      end
   end

   // Result registers, loaded on the last drain edge so the final bit is included.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         out_ones_q    <= 8'd0;
         out_bipolar_q <= 9'sd0;
      end else if (state_q == StDrain && state_d == StDone) begin
         out_ones_q    <= ones_next;
         out_bipolar_q <= bip_next[8:0];
      end
   end

   assign out_ones    = out_ones_q;
   assign out_bipolar = out_bipolar_q;

endmodule

// File: tb/tb_sc_mul_sequencer.sv
// Self-checking bench for sc_mul_sequencer: vector table, corner sequences, random sweep.
module tb_sc_mul_sequencer;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_prob_a = 4'd0;
   logic [3:0]        in_prob_b = 4'd0;
   logic [1:0]        in_len = 2'd0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [7:0]        out_ones;
   logic signed [8:0] out_bipolar;
   logic              busy;

   int tests = 0;
   int fails = 0;
   int expect_results = 0;
   int got_results = 0;

   typedef struct {
      int ones;
      int bip;
      int n;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0] pa;
      logic [3:0] pb;
      logic [1:0] len;
      int         ones;
   } vec_t;
   vec_t vecs[13];

   sc_mul_sequencer #(
      .SEED_A (31'd1),
      .SEED_B (31'd2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_prob_a   (in_prob_a),
      .in_prob_b   (in_prob_b),
      .in_len      (in_len),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ones    (out_ones),
      .out_bipolar (out_bipolar),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Reference: step the LFSRs from the seeds N times, counting XNOR ones.
   function automatic int model_ones(input logic [3:0] pa, input logic [3:0] pb,
                                     input logic [1:0] len);
      logic [30:0] a = 31'd1;
      logic [30:0] b = 31'd2;
      int          n = 16 << len;
      int          ones = 0;
      logic        ba, bb;
      for (int k = 0; k < n; k++) begin
         ba = (a[30:27] < pa);
         bb = (b[30:27] < pb);
         if (ba == bb) ones++;
         a = {a[29:0], a[27] ^ a[30]};
         b = {b[29:0], b[12] ^ b[16]};
      end
      return ones;
   endfunction

   // Scoreboard pop on every result handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_has_entry", 0, 1);
         end else begin
            e = sb.pop_front();
            check("ones", int'(out_ones), e.ones);
            check("bipolar", int'(out_bipolar), e.bip);
            check("ones_in_range", int'(out_ones) <= e.n, 1);
            got_results++;
         end
      end
   end

   // Offer a job from IDLE; returns just after the accept edge.
   task automatic send(input logic [3:0] pa, input logic [3:0] pb, input logic [1:0] len,
                       input int ones);
      int   guard = 0;
      exp_t e;
      in_prob_a = pa;
      in_prob_b = pb;
      in_len    = len;
      in_valid  = 1'b1;
      while (in_ready !== 1'b1 && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("accept_in_time", guard < 300, 1);
      @(posedge clk);
      e.n    = 16 << len;
      e.ones = ones;
      e.bip  = 2 * ones - e.n;
      sb.push_back(e);
      expect_results++;
      #1;
      in_valid = 1'b0;
   endtask

   // Wait for out_valid; cycle t0+k is the period after edge t0+k-1, so the
   // DONE period is t0+N+4 when out_valid appears after edge t0+N+3.
   task automatic wait_done(input string tag, input int n);
      int lat = 0;
      bit ok  = 1'b1;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      end while (out_valid !== 1'b1 && lat < n + 20);
      check({tag, "_latency"}, lat + 1, n + 4);
      check({tag, "_busy_noready"}, ok, 1);
   endtask

   // With out_ready high the handshake lands on the next edge; IDLE follows.
   task automatic finish_job(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_idle_ready"}, in_ready, 1);
      check({tag, "_idle_novalid"}, out_valid, 0);
      check({tag, "_idle_notbusy"}, busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_out_ones"}, int'(out_ones), 0);
      check({tag, "_out_bipolar"}, int'(out_bipolar), 0);
   endtask

   initial begin
      int         first_ones, first_bip, ones;
      bit         stable;
      logic [3:0] pa, pb;
      logic [1:0] len;

      // Hand-derived rows: within 16 steps both LFSR nibbles stay 0; for 32
      // steps A's nibble is nonzero only at steps 27..30 (1, 2, 4, 8).
      vecs[0]  = '{4'd0,  4'd0,  2'd0, 16};
      vecs[1]  = '{4'd0,  4'd0,  2'd3, 128};
      vecs[2]  = '{4'd5,  4'd9,  2'd0, 16};
      vecs[3]  = '{4'd0,  4'd7,  2'd0, 0};
      vecs[4]  = '{4'd15, 4'd0,  2'd0, 0};
      vecs[5]  = '{4'd1,  4'd0,  2'd1, 4};
      vecs[6]  = '{4'd8,  4'd0,  2'd1, 1};
      vecs[7]  = '{4'd3,  4'd0,  2'd1, 2};
      vecs[8]  = '{4'd9,  4'd0,  2'd1, 0};
      // Model-derived rows
      vecs[9]  = '{4'd0,  4'd8,  2'd3, model_ones(4'd0, 4'd8, 2'd3)};
      vecs[10] = '{4'd7,  4'd12, 2'd2, model_ones(4'd7, 4'd12, 2'd2)};
      vecs[11] = '{4'd15, 4'd15, 2'd3, model_ones(4'd15, 4'd15, 2'd3)};
      vecs[12] = '{4'd4,  4'd11, 2'd1, model_ones(4'd4, 4'd11, 2'd1)};

      // Reset state, during and after reset
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_released");

      // Vector table; out_ready high so consecutive jobs run back-to-back
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         send(vecs[i].pa, vecs[i].pb, vecs[i].len, vecs[i].ones);
         wait_done("vec", 16 << vecs[i].len);
         finish_job("vec");
      end

      // Same job twice back-to-back
      ones = model_ones(4'd6, 4'd10, 2'd2);
      for (int i = 0; i < 2; i++) begin
         send(4'd6, 4'd10, 2'd2, ones);
         wait_done("b2b", 64);
         finish_job("b2b");
      end

      // Result held in DONE while out_ready is low; in_valid pulses ignored
      out_ready = 1'b0;
      send(4'd3, 4'd12, 2'd1, model_ones(4'd3, 4'd12, 2'd1));
      wait_done("hold", 32);
      first_ones = int'(out_ones);
      first_bip  = int'(out_bipolar);
      stable     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_prob_a = 4'($urandom_range(0, 15));
         in_valid  = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (out_valid !== 1'b1 || int'(out_ones) != first_ones ||
             int'(out_bipolar) != first_bip || in_ready !== 1'b0) stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      finish_job("hold");
      repeat (3) @(posedge clk);
      #1;
      check("hold_no_queued_job", busy, 0);

      // Reset in the middle of RUN discards the job
      send(4'd5, 4'd9, 2'd2, model_ones(4'd5, 4'd9, 2'd2));
      repeat (20) @(posedge clk);
      #1;
      check("midrun_busy", busy, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrun_rst");
      sb.delete();
      expect_results--;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      send(4'd10, 4'd3, 2'd2, model_ones(4'd10, 4'd3, 2'd2));
      wait_done("post_rst", 64);
      finish_job("post_rst");

      // Random sweep
      for (int i = 0; i < 200; i++) begin
         pa  = 4'($urandom_range(0, 15));
         pb  = 4'($urandom_range(0, 15));
         len = 2'($urandom_range(0, 3));
         send(pa, pb, len, model_ones(pa, pb, len));
         wait_done("rand", 16 << len);
         finish_job("rand");
      end

      repeat (2) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      check("result_count", got_results, expect_results);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
